// File: rtl/alarm_if.sv
// Alarm unit signal bundle: time counts and user controls in, alarm time/ring/state out.
interface alarm_if;
    logic       sec_tick;
    logic [5:0] count_sec;
    logic [5:0] count_min;
    logic [4:0] count_hour;
    logic       arm;
    logic       set_en;
    logic       inc_min;
    logic       inc_hour;
    logic       stop;
    logic       snooze;
    logic [5:0] alarm_min;
    logic [4:0] alarm_hour;
    logic       ring;
    logic [1:0] state;

    modport master (
        output sec_tick, count_sec, count_min, count_hour,
               arm, set_en, inc_min, inc_hour, stop, snooze,
        input  alarm_min, alarm_hour, ring, state
    );

    modport slave (
        input  sec_tick, count_sec, count_min, count_hour,
               arm, set_en, inc_min, inc_hour, stop, snooze,
        output alarm_min, alarm_hour, ring, state
    );
endinterface

// File: rtl/alarm_unit.sv
// Alarm stage: settable alarm time, DISARMED/ARMED/RINGING/SNOOZING FSM with timeout and snooze.
// Optional ALARM_BLINK_EN makes ring toggle on every sec_tick while RINGING.
module alarm_unit #(
    parameter int RING_SECONDS    = 60,
    parameter int SNOOZE_SECONDS  = 300,
    parameter int ALARM_HOUR_INIT = 6,
    parameter int ALARM_MIN_INIT  = 0
) (
    input  logic   clk,
    input  logic   reset,
    alarm_if.slave bus
);
    localparam logic [1:0] S_DIS  = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_RING = 2'd2;
    localparam logic [1:0] S_SNZ  = 2'd3;

    localparam int RC_W = $clog2(RING_SECONDS + 1);
    localparam int SC_W = $clog2(SNOOZE_SECONDS + 1);
    localparam logic [RC_W-1:0] RING_MAX = RC_W'(RING_SECONDS);
    localparam logic [SC_W-1:0] SNZ_LOAD = SC_W'(SNOOZE_SECONDS);
    localparam logic [SC_W-1:0] SNZ_ONE  = SC_W'(1);

    logic [1:0]      state_q, state_d;
    logic [RC_W-1:0] ring_cnt, ring_cnt_d, ring_inc;
    logic [SC_W-1:0] snz_cnt, snz_cnt_d;
    logic [5:0]      amin;
    logic [4:0]      ahour;
    logic            match, match_q, trigger, ring_q;

    assign match   = (bus.count_hour == ahour) && (bus.count_min == amin) && (bus.count_sec == 6'd0);
    // Edge-detect so a whole matching second yields one trigger; edits never fire it.
    assign trigger = match && !match_q && !bus.set_en;
    assign ring_inc = ring_cnt + 1'b1;

    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt;
        snz_cnt_d  = snz_cnt;
        case (state_q)
            S_DIS: if (bus.arm) state_d = S_ARM;
            S_ARM: begin
                if (!bus.arm) state_d = S_DIS;
                else if (trigger) begin
                    state_d    = S_RING;
                    ring_cnt_d = '0;
                end
            end
            S_RING: begin
                if (!bus.arm) state_d = S_DIS;
                else if (bus.stop) state_d = S_ARM;
                else if (bus.snooze) begin
                    state_d   = S_SNZ;
                    snz_cnt_d = SNZ_LOAD;
                end else if (bus.sec_tick) begin
                    ring_cnt_d = ring_inc;
                    if (ring_inc == RING_MAX) state_d = S_ARM;
                end
            end
            default: begin
                if (!bus.arm) state_d = S_DIS;
                else if (bus.stop) state_d = S_ARM;
                else if (bus.sec_tick) begin
                    if (snz_cnt == SNZ_ONE) begin
                        state_d    = S_RING;
                        ring_cnt_d = '0;
                    end
                    if (snz_cnt != '0) snz_cnt_d = snz_cnt - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_DIS;
            ring_cnt <= '0;
            snz_cnt  <= '0;
            match_q  <= 1'b0;
            amin     <= 6'(ALARM_MIN_INIT);
            ahour    <= 5'(ALARM_HOUR_INIT);
        end else begin
            state_q  <= state_d;
            ring_cnt <= ring_cnt_d;
            snz_cnt  <= snz_cnt_d;
            match_q  <= match;
            if (bus.set_en) begin
                if (bus.inc_min)  amin  <= (amin == 6'd59)  ? 6'd0 : amin + 6'd1;
                if (bus.inc_hour) ahour <= (ahour == 5'd23) ? 5'd0 : ahour + 5'd1;
            end
        end
    end

`ifdef ALARM_BLINK_EN
    logic blink_ph;

    // Phase restarts at 1 on every entry into RINGING, then flips per tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_ph <= 1'b0;
            ring_q   <= 1'b0;
        end else begin
            if (state_d == S_RING && state_q != S_RING) blink_ph <= 1'b1;
            else if (state_q == S_RING && bus.sec_tick) blink_ph <= ~blink_ph;
            ring_q <= (state_q == S_RING) && blink_ph;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) ring_q <= 1'b0;
        else       ring_q <= (state_q == S_RING);
    end
`endif

    assign bus.state      = state_q;
    assign bus.ring       = ring_q;
    assign bus.alarm_min  = amin;
    assign bus.alarm_hour = ahour;
endmodule

// File: tb/tb_alarm_unit.sv
// Directed self-checking bench for alarm_unit.
module tb_alarm_unit;
    logic clk, reset;
    int n_checks = 0;
    int n_fail   = 0;

    alarm_if ai();

    alarm_unit #(
        .RING_SECONDS(60), .SNOOZE_SECONDS(300),
        .ALARM_HOUR_INIT(6), .ALARM_MIN_INIT(0)
    ) dut (
        .clk(clk), .reset(reset), .bus(ai.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sec(input int n);
        for (int i = 0; i < n; i++) begin
            ai.sec_tick = 1'b1; step();
            ai.sec_tick = 1'b0; step();
        end
    endtask

    task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        ai.count_hour = h; ai.count_min = m; ai.count_sec = s;
    endtask

    // Leave and re-enter 06:00:00 so match has a fresh rising edge.
    task automatic ring_up();
        set_time(5'd6, 6'd0, 6'd1); step();
        set_time(5'd6, 6'd0, 6'd0); step();
    endtask

    task automatic test_reset();
        reset = 1'b1; step(); reset = 1'b0;
        n_checks++; if (ai.state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", ai.state); end
        n_checks++; if (ai.ring !== 1'b0) begin n_fail++; $display("FAIL reset_ring got %0b exp 0", ai.ring); end
        n_checks++; if (ai.alarm_hour !== 5'd6) begin n_fail++; $display("FAIL reset_hour got %0d exp 6", ai.alarm_hour); end
        n_checks++; if (ai.alarm_min !== 6'd0) begin n_fail++; $display("FAIL reset_min got %0d exp 0", ai.alarm_min); end
    endtask

    task automatic test_edit();
        ai.inc_min = 1'b1; step(); ai.inc_min = 1'b0;
        n_checks++; if (ai.alarm_min !== 6'd0) begin n_fail++; $display("FAIL edit_ignored got %0d exp 0", ai.alarm_min); end
        ai.set_en = 1'b1;
        repeat (59) begin ai.inc_min = 1'b1; step(); ai.inc_min = 1'b0; end
        n_checks++; if (ai.alarm_min !== 6'd59) begin n_fail++; $display("FAIL edit_min59 got %0d exp 59", ai.alarm_min); end
        ai.inc_min = 1'b1; step(); ai.inc_min = 1'b0;
        n_checks++; if (ai.alarm_min !== 6'd0) begin n_fail++; $display("FAIL edit_min_wrap got %0d exp 0", ai.alarm_min); end
        n_checks++; if (ai.alarm_hour !== 5'd6) begin n_fail++; $display("FAIL edit_no_carry got %0d exp 6", ai.alarm_hour); end
        repeat (18) begin ai.inc_hour = 1'b1; step(); ai.inc_hour = 1'b0; end
        n_checks++; if (ai.alarm_hour !== 5'd0) begin n_fail++; $display("FAIL edit_hour_wrap got %0d exp 0", ai.alarm_hour); end
        ai.inc_min = 1'b1; ai.inc_hour = 1'b1; step(); ai.inc_min = 1'b0; ai.inc_hour = 1'b0;
        n_checks++; if (ai.alarm_min !== 6'd1 || ai.alarm_hour !== 5'd1)
            begin n_fail++; $display("FAIL edit_both got %0d:%0d exp 1:1", ai.alarm_hour, ai.alarm_min); end
        n_checks++; if (ai.state !== 2'd0) begin n_fail++; $display("FAIL edit_state got %0d exp 0", ai.state); end
        ai.set_en = 1'b0;
        reset = 1'b1; step(); reset = 1'b0;
    endtask

    task automatic test_trigger();
        ai.arm = 1'b1; step();
        n_checks++; if (ai.state !== 2'd1) begin n_fail++; $display("FAIL trig_armed got %0d exp 1", ai.state); end
        set_time(5'd5, 6'd59, 6'd59); step();
        n_checks++; if (ai.state !== 2'd1) begin n_fail++; $display("FAIL trig_early got %0d exp 1", ai.state); end
        set_time(5'd6, 6'd0, 6'd0); step();
        n_checks++; if (ai.state !== 2'd2) begin n_fail++; $display("FAIL trig_state got %0d exp 2", ai.state); end
        n_checks++; if (ai.ring !== 1'b0) begin n_fail++; $display("FAIL trig_ring_lat got %0b exp 0", ai.ring); end
        step();
        n_checks++; if (ai.ring !== 1'b1) begin n_fail++; $display("FAIL trig_ring got %0b exp 1", ai.ring); end
        sec(59);
        n_checks++; if (ai.state !== 2'd2) begin n_fail++; $display("FAIL timeout_59 got %0d exp 2", ai.state); end
        sec(1);
        n_checks++; if (ai.state !== 2'd1) begin n_fail++; $display("FAIL timeout_state got %0d exp 1", ai.state); end
        n_checks++; if (ai.ring !== 1'b0) begin n_fail++; $display("FAIL timeout_ring got %0b exp 0", ai.ring); end
    endtask

    task automatic test_snooze();
        ring_up();
        n_checks++; if (ai.state !== 2'd2) begin n_fail++; $display("FAIL snz_ringing got %0d exp 2", ai.state); end
        ai.snooze = 1'b1; step(); ai.snooze = 1'b0;
        n_checks++; if (ai.state !== 2'd3) begin n_fail++; $display("FAIL snz_enter got %0d exp 3", ai.state); end
        sec(100);
        ai.snooze = 1'b1; step(); ai.snooze = 1'b0;
        n_checks++; if (ai.state !== 2'd3) begin n_fail++; $display("FAIL snz_ignored got %0d exp 3", ai.state); end
        sec(199);
        n_checks++; if (ai.state !== 2'd3) begin n_fail++; $display("FAIL snz_299 got %0d exp 3", ai.state); end
        sec(1);
        n_checks++; if (ai.state !== 2'd2) begin n_fail++; $display("FAIL snz_300 got %0d exp 2", ai.state); end
        n_checks++; if (ai.ring !== 1'b1) begin n_fail++; $display("FAIL snz_rering got %0b exp 1", ai.ring); end
        ai.stop = 1'b1; step(); ai.stop = 1'b0;
        n_checks++; if (ai.state !== 2'd1) begin n_fail++; $display("FAIL snz_stop got %0d exp 1", ai.state); end
    endtask

    task automatic test_no_retrigger();
        ring_up();
        ai.stop = 1'b1; step(); ai.stop = 1'b0;
        repeat (5) step();
        n_checks++; if (ai.state !== 2'd1) begin n_fail++; $display("FAIL noretrig_stop got %0d exp 1", ai.state); end
        ai.arm = 1'b0; step();
        n_checks++; if (ai.state !== 2'd0) begin n_fail++; $display("FAIL noretrig_disarm got %0d exp 0", ai.state); end
        ai.arm = 1'b1; step(); repeat (3) step();
        n_checks++; if (ai.state !== 2'd1) begin n_fail++; $display("FAIL noretrig_rearm got %0d exp 1", ai.state); end
        ring_up();
        ai.stop = 1'b1; ai.snooze = 1'b1; step(); ai.stop = 1'b0; ai.snooze = 1'b0;
        n_checks++; if (ai.state !== 2'd1) begin n_fail++; $display("FAIL stop_snooze got %0d exp 1", ai.state); end
        ring_up();
        ai.arm = 1'b0; step();
        n_checks++; if (ai.state !== 2'd0) begin n_fail++; $display("FAIL ring_disarm got %0d exp 0", ai.state); end
        ai.arm = 1'b1; step();
    endtask

    task automatic test_edit_suppress();
        set_time(5'd6, 6'd1, 6'd0); step();
        ai.set_en = 1'b1;
        ai.inc_min = 1'b1; step(); ai.inc_min = 1'b0;
        n_checks++; if (ai.alarm_min !== 6'd1) begin n_fail++; $display("FAIL supp_min got %0d exp 1", ai.alarm_min); end
        step();
        ai.set_en = 1'b0;
        repeat (3) step();
        n_checks++; if (ai.state !== 2'd1) begin n_fail++; $display("FAIL supp_state got %0d exp 1", ai.state); end
    endtask

    task automatic test_reset_mid();
        set_time(5'd6, 6'd1, 6'd1); step();
        set_time(5'd6, 6'd1, 6'd0); step();
        ai.snooze = 1'b1; step(); ai.snooze = 1'b0;
        n_checks++; if (ai.state !== 2'd3) begin n_fail++; $display("FAIL mid_snz got %0d exp 3", ai.state); end
        reset = 1'b1; step(); reset = 1'b0;
        n_checks++; if (ai.state !== 2'd0 || ai.ring !== 1'b0)
            begin n_fail++; $display("FAIL mid_snz_reset got state %0d ring %0b exp 0/0", ai.state, ai.ring); end
        n_checks++; if (ai.alarm_min !== 6'd0 || ai.alarm_hour !== 5'd6)
            begin n_fail++; $display("FAIL mid_alarm got %0d:%0d exp 6:0", ai.alarm_hour, ai.alarm_min); end
        step();
        set_time(5'd6, 6'd0, 6'd0); step(); step();
        n_checks++; if (ai.state !== 2'd2 || ai.ring !== 1'b1)
            begin n_fail++; $display("FAIL mid_ring got state %0d ring %0b exp 2/1", ai.state, ai.ring); end
        reset = 1'b1; step(); reset = 1'b0;
        n_checks++; if (ai.state !== 2'd0 || ai.ring !== 1'b0)
            begin n_fail++; $display("FAIL mid_ring_reset got state %0d ring %0b exp 0/0", ai.state, ai.ring); end
        step();
    endtask

    task automatic test_blink();
        logic [3:0] exp_seq;
        ring_up(); step();
        n_checks++; if (ai.ring !== 1'b1) begin n_fail++; $display("FAIL blink_start got %0b exp 1", ai.ring); end
`ifdef ALARM_BLINK_EN
        exp_seq = 4'b1010;
`else
        exp_seq = 4'b1111;
`endif
        for (int i = 0; i < 4; i++) begin
            sec(1);
            n_checks++; if (ai.ring !== exp_seq[i])
                begin n_fail++; $display("FAIL blink_tick%0d got %0b exp %0b", i, ai.ring, exp_seq[i]); end
        end
        ai.stop = 1'b1; step(); ai.stop = 1'b0;
        n_checks++; if (ai.state !== 2'd1) begin n_fail++; $display("FAIL blink_stop got %0d exp 1", ai.state); end
        step();
        n_checks++; if (ai.ring !== 1'b0) begin n_fail++; $display("FAIL blink_off got %0b exp 0", ai.ring); end
    endtask

    initial begin
        reset = 1'b0;
        ai.sec_tick = 1'b0; ai.arm = 1'b0; ai.set_en = 1'b0;
        ai.inc_min = 1'b0; ai.inc_hour = 1'b0; ai.stop = 1'b0; ai.snooze = 1'b0;
        set_time(5'd0, 6'd0, 6'd0);
        test_reset();
        test_edit();
        test_trigger();
        test_snooze();
        test_no_retrigger();
        test_edit_suppress();
        test_reset_mid();
        test_blink();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alarm_unit.md
# alarm_unit

Alarm stage downstream of the HH:MM:SS up/down time counter. It consumes the binary hour/minute/second counts and a one-cycle per-second tick. It holds a user-settable alarm time and runs a DISARMED/ARMED/RINGING/SNOOZING state machine that drives a ring output, with auto-timeout and snooze. Its alarm time outputs feed a spare pair of BCD display decoders in set mode.

## Interface
- `RING_SECONDS`, 60: sec_ticks spent in RINGING before auto-timeout to ARMED (1..255).
- `SNOOZE_SECONDS`, 300: sec_ticks spent in SNOOZING before re-ringing (1..1023).
- `ALARM_HOUR_INIT`, 6: alarm hour loaded on reset (0..23).
- `ALARM_MIN_INIT`, 0: alarm minute loaded on reset (0..59).

- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `sec_tick` in 1: one-cycle pulse, once per counted second.
- `count_sec` in 6: current seconds, binary 0..59.
- `count_min` in 6: current minutes, binary 0..59.
- `count_hour` in 5: current hours, binary 0..23.
- `arm` in 1: level; 1 = alarm enabled.
- `set_en` in 1: level; 1 = alarm-time edit mode.
- `inc_min` in 1: one-cycle debounced pulse; increment alarm minute.
- `inc_hour` in 1: one-cycle debounced pulse; increment alarm hour.
- `stop` in 1: one-cycle pulse; dismiss the alarm.
- `snooze` in 1: one-cycle pulse; snooze the alarm.
- `alarm_min` out 6: stored alarm minute.
- `alarm_hour` out 5: stored alarm hour.
- `ring` out 1: alarm sounding indicator, registered.
- `state` out 2: encoding 0 DISARMED, 1 ARMED, 2 RINGING, 3 SNOOZING.

## Operation
- **Alarm time edit**
  - `inc_min` and `inc_hour` act only while `set_en`=1 and are ignored otherwise.
  - Minute wraps 59→0 with no carry into the hour. Hour wraps 23→0.
  - Simultaneous `inc_min` and `inc_hour` both apply in the same cycle.
  - Editing never changes state.
- **Match detection**
  - `match` = (`count_hour`==`alarm_hour`) & (`count_min`==`alarm_min`) & (`count_sec`==0).
  - `match_q` is `match` registered.
  - `trigger` = `match` & ~`match_q` & ~`set_en`, so there is one trigger per entry into the matching second.
  - This holds for both count directions.
- **Transitions** (priority top-down within each state)
  - DISARMED: `arm`=1 → ARMED.
  - ARMED: `arm`=0 → DISARMED; else `trigger` → RINGING, clear `ring_cnt`.
  - RINGING:
    - `arm`=0 → DISARMED.
    - else `stop` → ARMED.
    - else `snooze` → SNOOZING, load `snz_cnt` = `SNOOZE_SECONDS`.
    - else on `sec_tick`, `ring_cnt`++; when `ring_cnt` reaches `RING_SECONDS` → ARMED.
  - SNOOZING:
    - `arm`=0 → DISARMED.
    - else `stop` → ARMED.
    - else on `sec_tick`, `snz_cnt`--; a `sec_tick` when `snz_cnt`==1 → RINGING, clear `ring_cnt`.
    - `snooze` is ignored in this state.
- `ring` is 1 only in RINGING (steady unless `ALARM_BLINK_EN`).
- Counter widths are sized with `$clog2(param+1)`. The counters do not wrap.

## Timing
- **Reset values:**
  - `state`=DISARMED, `ring`=0
  - `alarm_hour`=`ALARM_HOUR_INIT`, `alarm_min`=`ALARM_MIN_INIT`
  - `match_q`=0, `ring_cnt`=0, `snz_cnt`=0
- **Latencies:**
  - All inputs are sampled at posedge. State and alarm registers update 1 cycle after the input.
  - `ring` rises the cycle after `state` enters RINGING, i.e. 2 cycles after the count reaches the alarm time.
  - `ring` falls 1 cycle after the state leaves RINGING.
- **Boundary behaviour:**
  - `reset` mid-ring or mid-snooze returns everything to reset values on the next edge.
  - Arming while the time already matches triggers only if `match` has a rising edge after arming; a stale match does not trigger.
  - Deasserting and reasserting `arm` during the matching second does not retrigger.
  - Editing the alarm time onto the current time while `set_en`=1 does not trigger; the trigger is suppressed during edit.
  - `stop` and `snooze` in the same cycle resolve as `stop`.

## Configuration
- `ALARM_BLINK_EN` defined:
  - In RINGING, `ring` toggles on every `sec_tick`.
  - It starts at 1 on entry to RINGING and is forced to 0 on exit.
- `ALARM_BLINK_EN` undefined: `ring` is held steady at 1 throughout RINGING.

## Test plan
- **Reset:** assert `reset` 1 cycle → `state`=0, `ring`=0, `alarm_hour`=6, `alarm_min`=0.
- **Edit wrap:** `set_en`=1, 60 `inc_min` pulses → `alarm_min` returns to 0 with `alarm_hour` unchanged. 18 `inc_hour` pulses from 6 → `alarm_hour`=0.
- **Trigger and timeout:**
  - `arm`=1, drive counts to 06:00:00 → `state`=2 after 1 cycle, `ring`=1 after 2 cycles.
  - 60 `sec_tick`s → `state`=1, `ring`=0.
- **Snooze:**
  - While ringing, pulse `snooze` → `state`=3.
  - After 299 `sec_tick`s still `state`=3; the 300th → `state`=2.
  - Then `stop` → `state`=1.
- **No retrigger:** ringing, `stop` during the 06:00:00 second, further cycles within the same second → `state` stays 1. `arm`=0 while ringing → `state`=0.
- **Blink (`ALARM_BLINK_EN`):** ringing, 4 `sec_tick`s → `ring` sequence 1,0,1,0,1. `stop` → `ring`=0 the next cycle.
